// File: rtl/rr_arb_onehot.sv
// rr_arb_onehot: round-robin arbiter with a registered one-hot grant and a
// val/rdy output handshake. Feeds a one-hot encoder directly, so grant is
// always either all-zero or exactly one-hot.
//
// Parameters:
//   NREQS      number of requesters (2, 4, 8 or 16)
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous active-low reset
//   req        request vector, any number of bits set
//   lock       (RR_ARB_ONEHOT_LOCK_EN only) keep current winner at top
//              priority on accept
//   grant_rdy  downstream accepts the current grant
//   grant_val  registered grant valid
//   grant      registered one-hot grant, zero when grant_val is low
//
// Optional feature: define RR_ARB_ONEHOT_LOCK_EN to add the lock input.

module rr_arb_onehot #(
  parameter int unsigned NREQS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQS-1:0] req,
`ifdef RR_ARB_ONEHOT_LOCK_EN
  input  logic             lock,
`endif
  input  logic             grant_rdy,
  output logic             grant_val,
  output logic [NREQS-1:0] grant
);

  localparam int unsigned IdxW = $clog2(NREQS);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StGrant = 1'b1;

  logic [0:0]       state_q, state_d;
  logic             val_q, val_d;
  logic [NREQS-1:0] grant_q, grant_d;
  logic [NREQS-1:0] ptr_q, ptr_d;
  logic [NREQS-1:0] ptr_next;

  // First set bit of r at or after the one-hot pointer p, wrapping. NREQS is
  // a power of two so the index sum wraps by truncation.
  function automatic logic [NREQS-1:0] arb(input logic [NREQS-1:0] r,
                                           input logic [NREQS-1:0] p);
    logic [IdxW-1:0]  base;
    logic [IdxW-1:0]  idx;
    logic [NREQS-1:0] res;
    logic             found;
    base  = '0;
    res   = '0;
    found = 1'b0;
    for (int i = 0; i < NREQS; i++) begin
      if (p[i]) base = IdxW'(i);
    end
    for (int off = 0; off < NREQS; off++) begin
      idx = base + IdxW'(off);
      if (!found && r[idx]) begin
        res[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return res;
  endfunction

  always_comb begin
    // Rotating past the winner puts it at lowest priority next time round.
    ptr_next = {grant_q[NREQS-2:0], grant_q[NREQS-1]};
`ifdef RR_ARB_ONEHOT_LOCK_EN
    if (lock) ptr_next = grant_q;
`endif
  end

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      StIdle: begin
        if (|req) begin
          grant_d = arb(req, ptr_q);
          val_d   = 1'b1;
          state_d = StGrant;
        end
      end
      StGrant: begin
        // Stalled: everything holds and req is ignored.
        if (grant_rdy) begin
          ptr_d = ptr_next;
          if (|req) begin
            grant_d = arb(req, ptr_next);
          end else begin
            grant_d = '0;
            val_d   = 1'b0;
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
        val_d   = 1'b0;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      val_q   <= 1'b0;
      grant_q <= '0;
      ptr_q   <= NREQS'(1);
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  assign grant_val = val_q;
  assign grant     = grant_q;

endmodule

// File: tb/tb_rr_arb_onehot.sv
module tb_rr_arb_onehot;

  localparam int unsigned NREQS = 16;

  logic             clk;
  logic             reset;
  logic [NREQS-1:0] req;
  logic             lock;
  logic             grant_rdy;
  logic             grant_val;
  logic [NREQS-1:0] grant;

  int n_checks;
  int n_fail;

  // Reference model: requester indices as plain integers.
  bit m_busy;
  int m_gidx;
  int m_ptr;

  rr_arb_onehot #(
    .NREQS(NREQS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
`ifdef RR_ARB_ONEHOT_LOCK_EN
    .lock     (lock),
`endif
    .grant_rdy(grant_rdy),
    .grant_val(grant_val),
    .grant    (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int arb_idx(input logic [NREQS-1:0] r, input int p);
    int i;
    for (int k = 0; k < NREQS; k++) begin
      i = (p + k) % NREQS;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [NREQS-1:0] exp_grant();
    logic [NREQS-1:0] g;
    g = '0;
    if (m_busy) g[m_gidx] = 1'b1;
    return g;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0;
    m_gidx = 0;
    m_ptr  = 0;
  endtask

  // Applies the arbitration rules to the inputs present at the edge.
  task automatic model_edge();
    bit use_lock;
    use_lock = 1'b0;
`ifdef RR_ARB_ONEHOT_LOCK_EN
    use_lock = lock;
`endif
    if (!reset) begin
      model_reset();
    end else if (!m_busy) begin
      if (req != '0) begin
        m_gidx = arb_idx(req, m_ptr);
        m_busy = 1'b1;
      end
    end else if (grant_rdy) begin
      m_ptr = use_lock ? m_gidx : (m_gidx + 1) % NREQS;
      if (req != '0) m_gidx = arb_idx(req, m_ptr);
      else           m_busy = 1'b0;
    end
  endtask

  task automatic check_model(input string tag);
    check_eq({tag, ".val"}, 32'(grant_val), 32'(m_busy));
    check_eq({tag, ".grant"}, 32'(grant), 32'(exp_grant()));
    check_eq({tag, ".onehot"}, 32'($countones(grant) <= 1), 32'd1);
  endtask

  task automatic step(input logic [NREQS-1:0] r, input logic rdy, input string tag);
    req       = r;
    grant_rdy = rdy;
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b0;
    req       = 16'hFFFF;
    grant_rdy = 1'b1;
    lock      = 1'b0;
    model_reset();

    // 1. Reset held with all requests pending.
    #1;
    step(16'hFFFF, 1'b1, "rst0");
    step(16'hFFFF, 1'b1, "rst1");
    check_eq("rst.grant", 32'(grant), 32'h0);
    reset = 1'b1;
    step(16'hFFFF, 1'b1, "first");
    check_eq("first.grant", 32'(grant), 32'h0001);

    // 2. Full rotation, no bubbles.
    for (int i = 1; i <= NREQS; i++) begin
      step(16'hFFFF, 1'b1, "rot");
      check_eq("rot.seq", 32'(grant), 32'(1) << (i % NREQS));
    end
    step(16'h0000, 1'b1, "drain2");

    // 3. Stall holds grant, late req changes ignored.
    for (int i = 0; i < 3; i++) step(16'h0012, 1'b0, "stall");
    check_eq("stall.grant", 32'(grant), 32'h0002);
    step(16'h0010, 1'b0, "stall_chg");
    check_eq("stall_chg.grant", 32'(grant), 32'h0002);
    step(16'h0010, 1'b1, "stall_acc");
    check_eq("stall_acc.grant", 32'(grant), 32'h0010);
    step(16'h0000, 1'b1, "drain3");

    // 4. Wrap from bit 15 and re-grant of the accepting requester.
    step(16'h8000, 1'b0, "wrap0");
    check_eq("wrap0.grant", 32'(grant), 32'h8000);
    step(16'h8001, 1'b1, "wrap1");
    check_eq("wrap1.grant", 32'(grant), 32'h0001);
    step(16'h8000, 1'b1, "skip");
    check_eq("skip.grant", 32'(grant), 32'h8000);
    step(16'h0000, 1'b1, "drain4");

    // 5. Drain to idle and restart.
    step(16'h0100, 1'b0, "single");
    check_eq("single.grant", 32'(grant), 32'h0100);
    step(16'h0000, 1'b1, "idle");
    check_eq("idle.val", 32'(grant_val), 32'h0);
    step(16'h0001, 1'b0, "restart");
    check_eq("restart.grant", 32'(grant), 32'h0001);
    step(16'h0000, 1'b1, "drain5");

    // 6. Asynchronous reset between edges.
    step(16'h0004, 1'b0, "pre_rst");
    check_eq("pre_rst.grant", 32'(grant), 32'h0004);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_eq("arst.val", 32'(grant_val), 32'h0);
    check_eq("arst.grant", 32'(grant), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(16'hFFFF, 1'b1, "post_rst");
    check_eq("post_rst.grant", 32'(grant), 32'h0001);
    step(16'h0000, 1'b1, "drain6");

`ifdef RR_ARB_ONEHOT_LOCK_EN
    // 7. Lock keeps the winner on top.
    lock = 1'b1;
    step(16'h0006, 1'b0, "lock0");
    for (int i = 0; i < 4; i++) begin
      step(16'h0006, 1'b1, "lock");
      check_eq("lock.grant", 32'(grant), 32'h0002);
    end
    lock = 1'b0;
    step(16'h0000, 1'b1, "drain7");
`endif

    // Randomized traffic against the model, with rare async resets.
    for (int i = 0; i < 600; i++) begin
      logic [NREQS-1:0] r;
      r = NREQS'($urandom);
      if ($urandom_range(0, 2) == 0) r = r & NREQS'($urandom);
      if ($urandom_range(0, 5) == 0) r = '0;
`ifdef RR_ARB_ONEHOT_LOCK_EN
      lock = ($urandom_range(0, 3) == 0);
`endif
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b0;
        model_reset();
        #1;
        check_eq("rnd_arst.grant", 32'(grant), 32'h0);
        reset = 1'b1;
      end
      step(r, 1'($urandom_range(0, 1)), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_arb_onehot.md
Name: rr_arb_onehot

Overview:
- Round-robin arbiter among NREQS requesters with a registered one-hot grant and a val/rdy output handshake.
- Sits directly upstream of the 16-to-4 one-hot encoder. Its `grant` bus feeds the encoder `in_` unchanged.
- Guarantee to the encoder: `grant` is either all-zero or exactly one-hot, never multi-hot.

Parameters:
- NREQS, 16, number of requesters; legal values are 2, 4, 8, 16.

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- reset, input, 1, asynchronous, active-low reset; all state clears immediately while reset==0.
- req, input, NREQS, request vector; any number of bits may be set.
- grant_val, output, 1, grant valid; registered.
- grant_rdy, input, 1, downstream accepts the grant this cycle.
- grant, output, NREQS, registered one-hot grant; all-zero when grant_val==0.

Behaviour:
- State:
  - FSM with states IDLE and GRANT.
  - Output registers grant_val and grant.
  - Priority pointer ptr: one-hot, NREQS bits.
- Reset (reset==0, asynchronous, no clock edge needed):
  - state=IDLE, grant_val=0, grant=0, ptr=bit0.
  - Deassertion takes effect at the next rising edge.
- Arbitration function arb(req, ptr): scan bits starting at ptr's index, ascending, wrapping from NREQS-1 to 0. Result is the first set bit, as one-hot; zero if req==0.
- IDLE:
  - If req!=0 at an edge: grant<=arb(req,ptr), grant_val<=1, state<=GRANT.
  - Otherwise remain in IDLE.
  - Latency is 1 cycle from req visible to grant_val high.
- GRANT, grant_rdy==0 (stall):
  - grant, grant_val and ptr hold.
  - Changes on req, including deassertion of the granted bit, are ignored.
- GRANT, grant_rdy==1 (accept):
  - ptr_next = grant rotated left by 1, wrapping bit NREQS-1 to bit0.
  - ptr <= ptr_next.
  - If req!=0 in the same cycle: grant<=arb(req,ptr_next) and stay in GRANT (back-to-back, no bubble).
  - Else: grant<=0, grant_val<=0, state<=IDLE.
- The accepting requester's own req bit is still eligible in the back-to-back arbitration, but at lowest priority.
- grant_rdy is ignored in IDLE.
- ptr changes only on accept.
- No combinational path from req or grant_rdy to any output.

Optional Feature:
- Macro: RR_ARB_ONEHOT_LOCK_EN.
- With the macro defined:
  - Extra input port `lock`, 1 bit.
  - On an accept with lock==1, ptr_next = grant (no rotation), so the current winner keeps top priority for the next arbitration.
  - On an accept with lock==0, behaviour is as baseline.
  - lock is ignored when not accepting.
- Without the macro: the port is absent and the pointer always rotates on accept.

Test Plan:
1. Reset: hold reset=0 for 2 cycles with req=0xFFFF -> grant_val=0, grant=0x0000. Release reset, req=0xFFFF, grant_rdy=1 -> first grant=0x0001.
2. Full rotation: req=0xFFFF, grant_rdy=1 held -> grants 0x0001, 0x0002, 0x0004, …, 0x8000, 0x0001 on consecutive cycles, with grant_val continuously 1.
3. Stall/hold: req=0x0012, grant_rdy=0 for 3 cycles -> grant=0x0002 stable. Change req to 0x0010 while still stalled -> grant stays 0x0002. Set grant_rdy=1 -> next cycle grant=0x0010.
4. Wrap and skip: accept 0x8000, then req=0x8001 -> grant=0x0001. Accept with req=0x8000 only -> grant=0x8000.
5. Drain to idle: single req=0x0100 accepted while req drops to 0 in the same cycle -> next cycle grant_val=0, grant=0x0000. A new req=0x0001 -> grant=0x0001 one cycle later.
6. Async reset mid-grant: grant_val=1, grant=0x0004, drive reset=0 between edges -> grant_val=0 and grant=0 before the next edge. After release with req=0xFFFF -> grant=0x0001.
7. Lock, only with RR_ARB_ONEHOT_LOCK_EN defined: req=0x0006, lock=1 on each accept -> grant repeats 0x0002.
